accum_mc: RTL and testbench
===========================

# accum_mc

Multi-channel saturating accumulator: the parametrised successor of the single-channel 16-bit saturating accumulator. It keeps NCH independent signed running sums, one per channel, each updated from a shared tagged input stream. Sums are clamped to programmable bounds, or optionally wrapped, and each channel has a sticky overflow flag. A dump engine reads all channels out serially over a valid/ready port, with optional clear-on-read. It sits between the per-channel sample producers and the statistics/readout logic.

## Interface
- NCH, 4: number of channels, ≥2.
- CH_W, 2: channel index width, equal to clog2(NCH).
- DIN_W, 8: signed input width.
- ACC_W, 16: signed accumulator width, > DIN_W.
- MAX_BOUND, 2^(ACC_W-1)-1: signed upper clamp.
- MIN_BOUND, -(2^(ACC_W-1)-1): signed lower clamp, < MAX_BOUND.
- SAT_MODE, 1: 1 = clamp to bounds; 0 = two's-complement wrap at ACC_W.
- CLR_ON_READ, 1: 1 = a channel's acc and flag are cleared when that channel is captured for dump.
- clk  in  1  sole clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- din_en  in  1  input sample valid; no backpressure.
- din_ch  in  CH_W  target channel; values ≥ NCH are ignored (no update).
- din  in  DIN_W  signed sample.
- dump_start  in  1  request a full dump; sampled only when busy=0.
- busy  out  1  dump in progress.
- dout_valid  out  1  dump word valid.
- dout_ready  in  1  consumer accepts the word.
- dout_ch  out  CH_W  channel of the dump word.
- dout  out  ACC_W  signed accumulated value.
- dout_sat  out  1  sticky overflow flag of that channel at capture.

## Operation
- Per-channel state: acc[NCH] (ACC_W, signed) and flag[NCH].
- Update when din_en=1 and din_ch < NCH:
  - sum = sign-extended acc[din_ch] + sign-extended din, computed at ACC_W+1 bits.
  - SAT_MODE=1: sum < MIN_BOUND → MIN_BOUND; sum > MAX_BOUND → MAX_BOUND; else sum. Set flag if clamped.
  - SAT_MODE=0: acc takes sum[ACC_W-1:0]. Set flag if sum is outside the ACC_W signed range.
  - The flag is sticky until reset or clear-on-read.
- Dump FSM, two states:
  - IDLE: busy=0 and dout_valid=0. dump_start=1 captures channel 0 and goes to SEND.
  - SEND: busy=1 and dout_valid=1.
    - On a handshake (dout_valid & dout_ready) with dout_ch < NCH-1: capture channel dout_ch+1 and stay in SEND.
    - On a handshake with dout_ch = NCH-1: go to IDLE.
    - Without a handshake: dout, dout_ch and dout_sat are held stable.
- Capture: dout ← acc[ch] and dout_sat ← flag[ch], taking the register values before this cycle's update.
  - If CLR_ON_READ=1, the same edge clears acc[ch] and flag[ch].
- Capture and update on the same channel in the same cycle:
  - The captured value excludes din.
  - With CLR_ON_READ=1, the new acc[ch] = din (0 + din, clamp rules applied), and flag[ch] = the overflow result of that single add.
  - With CLR_ON_READ=0, the normal update applies and the snapshot is still the old value.
- dump_start while busy=1 is ignored; it is not queued.
- Accumulation continues on all channels during a dump.

## Timing
- Update latency: 1 cycle. acc reflects din on the edge after din_en.
- dump_start at edge N gives dout_valid=1 with channel 0 from edge N+1.
- Back-to-back handshakes give one word per cycle. A full dump takes NCH cycles when dout_ready is held at 1.
- After the final handshake at edge M, dout_valid=0 and busy=0 from edge M+1. A new dump_start is accepted at M+1.
- Reset, including mid-dump, takes effect on the next edge:
  - all acc = 0 and all flag = 0;
  - FSM = IDLE, busy = 0, dout_valid = 0;
  - dout = 0, dout_ch = 0, dout_sat = 0.
  - An aborted dump emits no further words.

## Test plan
- Basic accumulate: add +100 to ch1 three times, then dump → words (0,0,0), (1,300,0), (2,0,0), (3,0,0) on consecutive cycles with ready=1.
- Saturation: add +127 to ch2 259 times (32893 > 32767) → ch2 = 32767, flag=1. Then add -128 → 32639 and the flag stays 1. Repeat on ch3 with -128 to reach -32767.
- Wrap mode (SAT_MODE=0): ch0 at 32767 plus din=+1 → -32768, flag=1 on dump.
- Backpressure and collision: during a dump, hold ready=0 for 3 cycles → dout stays stable. On the cycle ch2 is captured (CLR_ON_READ=1, ch2=50), din_en for ch2 with din=+7 → dump shows 50, and a later dump shows ch2=7.
- Protocol edges: dump_start while busy is ignored. din_ch values ≥ NCH are ignored. CLR_ON_READ=0 keeps values across two dumps.
- Reset mid-dump: assert rst after word 1 → next edge has dout_valid=0, busy=0, all channels read 0 on the following dump.

Source files
------------

// File: rtl/accum_mc_if.sv
// Sample-input / dump-output bus of the multi-channel saturating accumulator.
interface accum_mc_if #(
  parameter int unsigned CH_W  = 2,
  parameter int unsigned DIN_W = 8,
  parameter int unsigned ACC_W = 16
);
  logic                    din_en;
  logic [CH_W-1:0]         din_ch;
  logic signed [DIN_W-1:0] din;
  logic                    dump_start;
  logic                    busy;
  logic                    dout_valid;
  logic                    dout_ready;
  logic [CH_W-1:0]         dout_ch;
  logic signed [ACC_W-1:0] dout;
  logic                    dout_sat;

  modport master (output din_en, din_ch, din, dump_start, dout_ready,
                  input  busy, dout_valid, dout_ch, dout, dout_sat);
  modport slave  (input  din_en, din_ch, din, dump_start, dout_ready,
                  output busy, dout_valid, dout_ch, dout, dout_sat);
endinterface

// File: rtl/accum_mc.sv
// NCH-channel signed accumulator with clamp/wrap, sticky overflow flags and a
// serial valid/ready dump engine with optional clear-on-read.
module accum_mc #(
  parameter int unsigned NCH         = 4,
  parameter int unsigned CH_W        = 2,
  parameter int unsigned DIN_W       = 8,
  parameter int unsigned ACC_W       = 16,
  parameter logic signed [ACC_W-1:0] MAX_BOUND = {1'b0, {(ACC_W-1){1'b1}}},
  parameter logic signed [ACC_W-1:0] MIN_BOUND = {1'b1, {(ACC_W-2){1'b0}}, 1'b1},
  parameter bit          SAT_MODE    = 1'b1,
  parameter bit          CLR_ON_READ = 1'b1
) (
  input  logic      clk,
  input  logic      rst,
  accum_mc_if.slave bus
);
  localparam int unsigned SUM_W = ACC_W + 1;
  localparam logic signed [SUM_W-1:0] MAX_X = {MAX_BOUND[ACC_W-1], MAX_BOUND};
  localparam logic signed [SUM_W-1:0] MIN_X = {MIN_BOUND[ACC_W-1], MIN_BOUND};
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NCH - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q  [NCH];
  logic signed [ACC_W-1:0] acc_d  [NCH];
  logic                    flag_q [NCH];
  logic                    flag_d [NCH];
  logic                    cap_en;
  logic [CH_W-1:0]         cap_ch;
  logic signed [ACC_W-1:0] cap_acc;
  logic                    cap_flag;

  // Dump sequencing: decides which channel (if any) is captured this edge.
  always_comb begin
    state_d = state_q;
    cap_en  = 1'b0;
    cap_ch  = '0;
    case (state_q)
      IDLE: begin
        if (bus.dump_start) begin
          cap_en  = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (bus.dout_ready) begin
          if (bus.dout_ch == LAST_CH) begin
            state_d = IDLE;
          end else begin
            cap_en = 1'b1;
            cap_ch = bus.dout_ch + CH_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Snapshot mux: pre-update register values of the captured channel.
  always_comb begin
    cap_acc  = '0;
    cap_flag = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (cap_ch == CH_W'(i)) begin
        cap_acc  = acc_q[i];
        cap_flag = flag_q[i];
      end
    end
  end

  // Per-channel next state; a clear-on-read capture zeroes the base before the add.
  always_comb begin : upd_p
    logic                    clr;
    logic signed [ACC_W-1:0] base;
    logic                    base_flag;
    logic signed [SUM_W-1:0] sum;
    logic signed [ACC_W-1:0] res;
    logic                    ovf;
    for (int unsigned i = 0; i < NCH; i++) begin
      clr       = CLR_ON_READ && cap_en && (cap_ch == CH_W'(i));
      base      = clr ? '0 : acc_q[i];
      base_flag = clr ? 1'b0 : flag_q[i];
      sum       = {base[ACC_W-1], base}
                + {{(SUM_W-DIN_W){bus.din[DIN_W-1]}}, bus.din};
      res       = sum[ACC_W-1:0];
      ovf       = 1'b0;
      if (SAT_MODE) begin
        if (sum < MIN_X) begin
          res = MIN_BOUND;
          ovf = 1'b1;
        end else if (sum > MAX_X) begin
          res = MAX_BOUND;
          ovf = 1'b1;
        end
      end else begin
        ovf = sum[SUM_W-1] != sum[ACC_W-1];
      end
      acc_d[i]  = base;
      flag_d[i] = base_flag;
      if (bus.din_en && (bus.din_ch == CH_W'(i))) begin
        acc_d[i]  = res;
        flag_d[i] = base_flag | ovf;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      bus.busy       <= 1'b0;
      bus.dout_valid <= 1'b0;
      bus.dout       <= '0;
      bus.dout_ch    <= '0;
      bus.dout_sat   <= 1'b0;
      for (int unsigned i = 0; i < NCH; i++) begin
        acc_q[i]  <= '0;
        flag_q[i] <= 1'b0;
      end
    end else begin
      state_q        <= state_d;
      bus.busy       <= (state_d == SEND);
      bus.dout_valid <= (state_d == SEND);
      for (int unsigned i = 0; i < NCH; i++) begin
        acc_q[i]  <= acc_d[i];
        flag_q[i] <= flag_d[i];
      end
      if (cap_en) begin
        bus.dout     <= cap_acc;
        bus.dout_ch  <= cap_ch;
        bus.dout_sat <= cap_flag;
      end
    end
  end
endmodule

// File: tb/tb_accum_mc.sv
// Directed bench: a clamp/clear-on-read 4-channel instance and a wrap/keep
// 3-channel instance checked against hand-computed dump words.
module tb_accum_mc;
  logic clk = 1'b0;
  logic rst;
  int   n_run  = 0;
  int   n_fail = 0;

  logic signed [15:0] exp_v [4];
  logic               exp_s [4];

  always #5 clk = ~clk;

  accum_mc_if #(.CH_W(2), .DIN_W(8), .ACC_W(16)) ia ();
  accum_mc_if #(.CH_W(2), .DIN_W(8), .ACC_W(16)) ib ();

  accum_mc #(.NCH(4), .CH_W(2), .DIN_W(8), .ACC_W(16),
             .SAT_MODE(1'b1), .CLR_ON_READ(1'b1))
    u_a (.clk(clk), .rst(rst), .bus(ia));

  accum_mc #(.NCH(3), .CH_W(2), .DIN_W(8), .ACC_W(16),
             .SAT_MODE(1'b0), .CLR_ON_READ(1'b0))
    u_b (.clk(clk), .rst(rst), .bus(ib));

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_a(input logic [1:0] ch, input logic signed [7:0] x, input int n);
    ia.din_en = 1'b1; ia.din_ch = ch; ia.din = x;
    repeat (n) tick();
    ia.din_en = 1'b0;
  endtask

  task automatic add_b(input logic [1:0] ch, input logic signed [7:0] x, input int n);
    ib.din_en = 1'b1; ib.din_ch = ch; ib.din = x;
    repeat (n) tick();
    ib.din_en = 1'b0;
  endtask

  task automatic dump_a(input string tag);
    ia.dout_ready = 1'b1;
    ia.dump_start = 1'b1;
    tick();
    ia.dump_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_w%0d_valid", tag, i), ia.dout_valid, 1);
      check($sformatf("%s_w%0d_busy", tag, i), ia.busy, 1);
      check($sformatf("%s_w%0d_ch", tag, i), ia.dout_ch, i);
      check($sformatf("%s_w%0d_val", tag, i), ia.dout, exp_v[i]);
      check($sformatf("%s_w%0d_sat", tag, i), ia.dout_sat, exp_s[i]);
      tick();
    end
    check($sformatf("%s_end_valid", tag), ia.dout_valid, 0);
    check($sformatf("%s_end_busy", tag), ia.busy, 0);
  endtask

  task automatic dump_b(input string tag);
    ib.dout_ready = 1'b1;
    ib.dump_start = 1'b1;
    tick();
    ib.dump_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s_w%0d_valid", tag, i), ib.dout_valid, 1);
      check($sformatf("%s_w%0d_ch", tag, i), ib.dout_ch, i);
      check($sformatf("%s_w%0d_val", tag, i), ib.dout, exp_v[i]);
      check($sformatf("%s_w%0d_sat", tag, i), ib.dout_sat, exp_s[i]);
      tick();
    end
    check($sformatf("%s_end_valid", tag), ib.dout_valid, 0);
    check($sformatf("%s_end_busy", tag), ib.busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    ia.din_en = 1'b0; ia.din_ch = '0; ia.din = '0; ia.dump_start = 1'b0; ia.dout_ready = 1'b0;
    ib.din_en = 1'b0; ib.din_ch = '0; ib.din = '0; ib.dump_start = 1'b0; ib.dout_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_valid", ia.dout_valid, 0);
    check("rst_busy", ia.busy, 0);
    check("rst_dout", ia.dout, 0);
    check("rst_ch", ia.dout_ch, 0);
    check("rst_sat", ia.dout_sat, 0);

    // Basic accumulate
    add_a(2'd1, 8'sd100, 3);
    exp_v = '{16'sd0, 16'sd300, 16'sd0, 16'sd0};
    exp_s = '{1'b0, 1'b0, 1'b0, 1'b0};
    dump_a("basic");

    // Saturation at both bounds, flag sticky after backing off
    add_a(2'd2, 8'sd127, 259);
    add_a(2'd2, -8'sd128, 1);
    add_a(2'd3, -8'sd128, 256);
    exp_v = '{16'sd0, 16'sd0, 16'sd32639, -16'sd32767};
    exp_s = '{1'b0, 1'b0, 1'b1, 1'b1};
    dump_a("sat");
    exp_v = '{16'sd0, 16'sd0, 16'sd0, 16'sd0};
    exp_s = '{1'b0, 1'b0, 1'b0, 1'b0};
    dump_a("cleared");

    // Backpressure, ignored dump_start while busy, capture/update collision
    add_a(2'd0, 8'sd33, 1);
    add_a(2'd2, 8'sd50, 1);
    ia.dout_ready = 1'b0;
    ia.dump_start = 1'b1;
    tick();
    ia.dump_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp%0d_valid", i), ia.dout_valid, 1);
      check($sformatf("bp%0d_ch", i), ia.dout_ch, 0);
      check($sformatf("bp%0d_val", i), ia.dout, 33);
      tick();
    end
    ia.dout_ready = 1'b1;
    tick();
    check("col_w1_ch", ia.dout_ch, 1);
    ia.din_en = 1'b1; ia.din_ch = 2'd2; ia.din = 8'sd7;
    ia.dump_start = 1'b1;
    tick();
    ia.din_en = 1'b0;
    ia.dump_start = 1'b0;
    check("col_w2_ch", ia.dout_ch, 2);
    check("col_w2_val", ia.dout, 50);
    check("col_w2_sat", ia.dout_sat, 0);
    tick();
    check("col_w3_ch", ia.dout_ch, 3);
    check("col_w3_val", ia.dout, 0);
    tick();
    check("col_end_valid", ia.dout_valid, 0);
    check("col_end_busy", ia.busy, 0);
    exp_v = '{16'sd0, 16'sd0, 16'sd7, 16'sd0};
    exp_s = '{1'b0, 1'b0, 1'b0, 1'b0};
    dump_a("post_col");

    // Wrap mode, out-of-range channel, values kept across dumps
    add_b(2'd0, 8'sd127, 258);
    add_b(2'd0, 8'sd1, 1);
    add_b(2'd0, 8'sd1, 1);
    add_b(2'd1, -8'sd5, 1);
    add_b(2'd3, 8'sd100, 2);
    exp_v = '{-16'sd32768, -16'sd5, 16'sd0, 16'sd0};
    exp_s = '{1'b1, 1'b0, 1'b0, 1'b0};
    dump_b("wrap1");
    dump_b("wrap2");

    // Reset in the middle of a dump
    add_a(2'd0, 8'sd9, 1);
    add_a(2'd3, 8'sd11, 1);
    ia.dout_ready = 1'b1;
    ia.dump_start = 1'b1;
    tick();
    ia.dump_start = 1'b0;
    check("mid_w0_val", ia.dout, 9);
    tick();
    check("mid_w1_ch", ia.dout_ch, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_valid", ia.dout_valid, 0);
    check("mid_rst_busy", ia.busy, 0);
    check("mid_rst_dout", ia.dout, 0);
    check("mid_rst_ch", ia.dout_ch, 0);
    check("mid_rst_sat", ia.dout_sat, 0);
    tick();
    check("mid_after_valid", ia.dout_valid, 0);
    exp_v = '{16'sd0, 16'sd0, 16'sd0, 16'sd0};
    exp_s = '{1'b0, 1'b0, 1'b0, 1'b0};
    dump_a("mid_a");
    dump_b("mid_b");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
